// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use detection, redirect squash,
// and the MEM-stage data-bus handshake with timeout, plus two saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dbus_ack,
  output logic             dbus_req,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic             bus_err,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_fire;
  logic        mem_stall;
  logic        load_use;
  logic        redirect_taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Bus handshake: ack always wins over a simultaneous timeout.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    dbus_req     = mem_access;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (mem_access && !dbus_ack) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = '0;
        end
      end
      WAIT: begin
        dbus_req     = 1'b1;
        timeout_fire = !dbus_ack && (wait_cnt == WAIT_LAST);
        if (dbus_ack || timeout_fire) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  assign bus_err   = timeout_fire;
  assign mem_stall = dbus_req && !dbus_ack && !timeout_fire;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Priority: bus freeze, then redirect, then load-use.
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_wb       = 1'b0;
    redirect_taken = 1'b0;
    if (mem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (ex_redirect) begin
      flush_id       = 1'b1;
      flush_ex       = 1'b1;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if)       perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (redirect_taken) perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4): directed scenarios plus random traffic
// against a cycle-level reference model built from the hazard/bus rules.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_redirect = 0;
  logic mem_access = 0, dbus_ack = 0;
  logic dbus_req, stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_wb, bus_err;
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pend = an access is outstanding from an earlier cycle; age = stall cycles it has cost.
  bit m_pend, nx_pend;
  int m_age, nx_age, m_sc, nx_sc, m_fc, nx_fc;
  logic [16:0] exp_vec;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dbus_ack(dbus_ack), .dbus_req(dbus_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb), .bus_err(bus_err),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] obs();
    return {dbus_req, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
            flush_wb, bus_err, perf_stall_cnt, perf_flush_cnt};
  endfunction

  task automatic model_eval();
    bit pend, rq, tf, ms, lu, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, red;
    int age, sc, fc;
    pend = rstn ? m_pend : 1'b0;
    age  = rstn ? m_age : 0;
    sc   = rstn ? m_sc : 0;
    fc   = rstn ? m_fc : 0;
    rq = mem_access || pend;
    tf = pend && !dbus_ack && (age == TO);
    ms = rq && !dbus_ack && !tf;
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, red} = '0;
    if (ms) {s_if, s_id, s_ex, s_mem, f_wb} = '1;
    else if (ex_redirect) {f_id, f_ex, red} = '1;
    else if (lu) {s_if, s_id, f_ex} = '1;
    exp_vec = {rq, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, tf, 4'(sc), 4'(fc)};
    nx_pend = ms;
    nx_age  = ms ? age + 1 : 0;
    nx_sc   = (s_if && sc < CMAX) ? sc + 1 : sc;
    nx_fc   = (red && fc < CMAX) ? fc + 1 : fc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) begin
      m_pend = 0; m_age = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_pend = nx_pend; m_age = nx_age; m_sc = nx_sc; m_fc = nx_fc;
    end
    #1;
  endtask

  task automatic set_in(bit ma, bit ack, bit red, bit mr, logic [4:0] rd,
                        logic [4:0] r1, logic [4:0] r2, bit u1, bit u2);
    mem_access = ma; dbus_ack = ack; ex_redirect = red; ex_memread = mr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    #2;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_eval();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_eval();
    n_checks++;
    if (obs() !== 17'h0) begin
      n_errors++; $display("FAIL reset_state act=%h exp=%h", obs(), 17'h0);
    end
    tick();
    // Stray ack with no access must be ignored.
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    model_eval();
    n_checks++;
    if (obs() !== exp_vec) begin
      n_errors++; $display("FAIL idle_ack act=%h exp=%h", obs(), exp_vec);
    end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_in(0, 0, 0, 1, 5, 0, 5, 0, 1);
        1: set_in(0, 0, 0, 1, 0, 0, 0, 1, 1);
        default: set_in(0, 0, 0, 1, 7, 7, 3, 0, 1);
      endcase
      model_eval();
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL load_use cyc=%0d act=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    n_checks++;
    if (perf_stall_cnt !== 4'd1) begin
      n_errors++; $display("FAIL load_use_cnt act=%0d exp=1", perf_stall_cnt);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    set_in(0, 0, 1, 1, 9, 9, 0, 1, 0);
    model_eval();
    n_checks++;
    if (obs() !== exp_vec) begin
      n_errors++; $display("FAIL redirect act=%h exp=%h", obs(), exp_vec);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 8'h01) begin
      n_errors++; $display("FAIL redirect_cnt act=%h exp=01", {perf_stall_cnt, perf_flush_cnt});
    end
  endtask

  task automatic test_bus_wait();
    int n_stall = 0, n_req = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(i < 4, i == 3, 1, 0, 0, 0, 0, 0, 0);
      model_eval();
      n_stall += stall_mem; n_req += dbus_req;
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL bus_wait cyc=%0d act=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    n_checks++;
    if (n_stall != 3 || n_req != 4) begin
      n_errors++; $display("FAIL bus_wait_len act=%0d/%0d exp=3/4", n_stall, n_req);
    end
  endtask

  task automatic test_timeout();
    int n_stall = 0, n_err = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, i == 7, 0, 0, 0, 0, 0, 0, 0);
      model_eval();
      if (i < 5) begin n_stall += stall_if; n_err += bus_err; end
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL timeout cyc=%0d act=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    n_checks++;
    if (n_stall != TO || n_err != 1) begin
      n_errors++; $display("FAIL timeout_len act=%0d/%0d exp=%0d/1", n_stall, n_err, TO);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      rstn = (i != 2);
      case (i)
        0, 1, 2: set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        3: set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
        default: set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      model_eval();
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL reset_mid_wait cyc=%0d act=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    rstn = 1'b1;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 1, 12, 12, 0, 1, 0);
      model_eval();
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL saturation cyc=%0d act=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (perf_stall_cnt !== 4'd15) begin
      n_errors++; $display("FAIL saturation_cnt act=%0d exp=15", perf_stall_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
      model_eval();
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL random cyc=%0d act=%h exp=%h", i, obs(), exp_vec);
      end
      tick();
    end
    rstn = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_bus_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It performs three jobs:
- detects load-use hazards between ID and EX;
- squashes wrong-path instructions on taken branches and jumps;
- runs the MEM-stage data-bus request/acknowledge handshake, freezing the pipeline while the bus is busy and timing out stuck accesses.

It drives the hold and bubble controls of the PC and every pipeline register and keeps two performance counters.

## Interface
Parameters:
- TIMEOUT, 255: maximum stalled cycles per data-bus access before forced completion; legal range 2..65535.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the instruction in ID reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the instruction in EX is a load.
- ex_redirect  in  1  the instruction in EX is a taken branch, jal or jalr.
- mem_access  in  1  the instruction in MEM is a load or store.
- dbus_ack  in  1  the data bus completes the current access this cycle.
- dbus_req  out  1  data-bus request for the MEM-stage access.
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers respectively.
- flush_id, flush_ex, flush_wb  out  1 each  load a bubble into IF/ID, ID/EX and MEM/WB respectively.
- bus_err  out  1  one-cycle pulse when an access is force-completed by timeout.
- perf_stall_cnt  out  CNT_W  cycles with stall_if high.
- perf_flush_cnt  out  CNT_W  cycles with ex_redirect acted on.

## Operation
Bus FSM (states IDLE, WAIT):
- dbus_req = mem_access in IDLE; dbus_req = 1 in WAIT.
- IDLE → WAIT when mem_access=1 and dbus_ack=0. The wait counter is cleared on entry.
- WAIT → IDLE when dbus_ack=1, or when wait_cnt = TIMEOUT-1. In the timeout case bus_err=1 for that cycle.
- In WAIT, wait_cnt increments every cycle it stays; it is 16 bits wide.

Memory stall:
- mem_stall = dbus_req & ~dbus_ack & ~timeout_fire.
- When mem_stall=1, this has the highest priority:
  - stall_if = stall_id = stall_ex = stall_mem = 1;
  - flush_wb = 1;
  - flush_id = flush_ex = 0.
- ex_redirect and load-use are ignored that cycle. They are re-evaluated once the freeze lifts, because the EX and ID contents are held.

Redirect (second priority, when mem_stall=0 and ex_redirect=1):
- flush_id = flush_ex = 1.
- All stalls are 0, so the PC takes the target.
- A load-use condition in the same cycle is suppressed.

Load-use (third priority):
- Condition: ex_memread & ex_rd≠0 & ((id_use_rs1 & id_rs1=ex_rd) | (id_use_rs2 & id_rs2=ex_rd)).
- Response: stall_if = stall_id = 1, flush_ex = 1, all else 0.
- Register x0 never causes a hazard.

Otherwise all stall and flush outputs are 0.

Performance counters:
- perf_stall_cnt increments in each cycle where stall_if=1.
- perf_flush_cnt increments in each cycle where the redirect branch is taken.
- Both saturate at all-ones; they do not wrap.

## Timing
- Stall, flush, dbus_req and bus_err are combinational from the inputs and the FSM state; the state and counters are registered.
- Zero-wait bus (dbus_ack in the same cycle as the request): no stall cycle; the FSM stays in IDLE.
- An access acknowledged N cycles after the request starts produces exactly N stalled cycles.
- Timeout produces exactly TIMEOUT stalled cycles, then one release cycle with bus_err=1 and dbus_req still 1.
- A new mem_access in the cycle right after release starts a fresh access from IDLE.
- Reset values (rstn=0, at any time including mid-WAIT):
  - FSM = IDLE, wait_cnt = 0, both perf counters = 0;
  - dbus_req follows mem_access, with no stale WAIT;
  - bus_err = 0.
- dbus_ack arriving in IDLE with mem_access=0 is ignored.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → stall_if=stall_id=flush_ex=1 for 1 cycle; perf_stall_cnt=1. Same stimulus with ex_rd=0 → no stall.
- Redirect plus load-use in the same cycle → flush_id=flush_ex=1, stall_if=0, perf_flush_cnt increments by 1, perf_stall_cnt unchanged.
- Bus wait: mem_access=1, dbus_ack raised 3 cycles later → dbus_req high for 4 cycles; all four stalls and flush_wb high for 3 cycles; FSM back in IDLE; ex_redirect held during the wait is acted on in the release cycle.
- Timeout with TIMEOUT=4 and dbus_ack never asserted → 4 stalled cycles, then bus_err=1 for 1 cycle with stalls 0; the next access starts from IDLE.
- rstn pulsed low during WAIT → immediate IDLE, counters 0; after reset with mem_access=1, dbus_ack=1 → no stall.
- Saturation with CNT_W=4: 20 consecutive load-use cycles → perf_stall_cnt holds at 15.
